mem_port_arbiter: RTL and testbench

Shares the single unified memory port between the instruction-fetch requester (IF) and the data load/store requester (DM). It sits between data_path and the memory model or bus. It sequences one outstanding transaction at a time through an accept / issue / complete FSM. Arbitration is fixed-priority to DM, with an anti-starvation override for IF and a per-transaction timeout.

---
 rtl/cpu_pkg.sv | 10 +
 rtl/arb_timeout_ctr.sv | 28 ++
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the memory-port arbiter: FSM states, requester identity and bus widths.
package cpu_pkg;

  localparam int unsigned BE_WIDTH = 4;

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, RESP} arb_state_t;

  typedef enum logic {REQ_IF, REQ_DM} requester_t;

endpackage

// File: rtl/arb_timeout_ctr.sv
// Saturating busy-cycle counter: counts while enabled, clears on request, flags LIMIT-1 reached.
module arb_timeout_ctr #(
  parameter int unsigned LIMIT = 64
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned CntW = (LIMIT > 2) ? $clog2(LIMIT) : 1;

  logic [CntW-1:0] count_q;

  assign o_expired = (count_q == CntW'(LIMIT - 1));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count_q <= '0;
    end else if (i_clr) begin
      count_q <= '0;
    end else if (i_en && !o_expired) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, one transaction at a time.
// DM has fixed priority; IF is forced after MAX_DM_STREAK consecutive DM grants it waited through.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MAX_DM_STREAK  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_if_req,
  input  logic [DATA_WIDTH-1:0] i_if_addr,
  output logic                  o_if_gnt,
  output logic                  o_if_rvalid,
  output logic [DATA_WIDTH-1:0] o_if_rdata,
  output logic                  o_if_err,
  input  logic                  i_dm_req,
  input  logic                  i_dm_we,
  input  logic [BE_WIDTH-1:0]   i_dm_be,
  input  logic [DATA_WIDTH-1:0] i_dm_addr,
  input  logic [DATA_WIDTH-1:0] i_dm_wdata,
  output logic                  o_dm_gnt,
  output logic                  o_dm_rvalid,
  output logic [DATA_WIDTH-1:0] o_dm_rdata,
  output logic                  o_dm_err,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [BE_WIDTH-1:0]   o_mem_be,
  output logic [DATA_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic                  i_mem_ack,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  localparam int unsigned StreakW = $clog2(MAX_DM_STREAK + 1);

  arb_state_t         state_q, state_d;
  requester_t         cur_q;
  logic [StreakW-1:0] streak_q;
  logic               if_gnt, dm_gnt;
  logic               busy, expired, done, force_if;

  assign busy     = (state_q == BUSY_IF) || (state_q == BUSY_DM);
  assign done     = busy && (i_mem_ack || expired);
  assign force_if = (streak_q == StreakW'(MAX_DM_STREAK));

  arb_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clr     (!busy),
    .i_en      (busy),
    .o_expired (expired)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (if_gnt) begin
          state_d = BUSY_IF;
        end else if (dm_gnt) begin
          state_d = BUSY_DM;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (done) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grants are gated by reset so every output reads 0 while reset is held.
  always_comb begin
    if_gnt      = 1'b0;
    dm_gnt      = 1'b0;
    o_if_rvalid = 1'b0;
    o_dm_rvalid = 1'b0;
    if (state_q == IDLE && i_reset_n) begin
      if (i_if_req && (!i_dm_req || force_if)) begin
        if_gnt = 1'b1;
      end else if (i_dm_req) begin
        dm_gnt = 1'b1;
      end
    end
    if (state_q == RESP) begin
      o_if_rvalid = (cur_q == REQ_IF);
      o_dm_rvalid = (cur_q == REQ_DM);
    end
  end

  assign o_if_gnt = if_gnt;
  assign o_dm_gnt = dm_gnt;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cur_q       <= REQ_IF;
      streak_q    <= '0;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_be    <= '0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_if_rdata  <= '0;
      o_if_err    <= 1'b0;
      o_dm_rdata  <= '0;
      o_dm_err    <= 1'b0;
    end else begin
      if (if_gnt) begin
        cur_q       <= REQ_IF;
        streak_q    <= '0;
        o_mem_req   <= 1'b1;
        o_mem_we    <= 1'b0;
        o_mem_be    <= '1;
        o_mem_addr  <= i_if_addr;
        o_mem_wdata <= '0;
      end else if (dm_gnt) begin
        cur_q       <= REQ_DM;
        // Only grants that made IF wait count towards the streak.
        streak_q    <= i_if_req ? streak_q + 1'b1 : '0;
        o_mem_req   <= 1'b1;
        o_mem_we    <= i_dm_we;
        o_mem_be    <= i_dm_be;
        o_mem_addr  <= i_dm_addr;
        o_mem_wdata <= i_dm_wdata;
      end
      if (done) begin
        o_mem_req <= 1'b0;
        if (cur_q == REQ_IF) begin
          o_if_rdata <= i_mem_ack ? i_mem_rdata : '0;
          o_if_err   <= !i_mem_ack;
        end else begin
          o_dm_rdata <= (i_mem_ack && !o_mem_we) ? i_mem_rdata : '0;
          o_dm_err   <= !i_mem_ack;
        end
      end
      if (state_q == RESP) begin
        o_if_err <= 1'b0;
        o_dm_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: memory responder, grant/completion scoreboard.
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        is_dm;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk, i_reset_n;
  logic        if_req, if_gnt, if_rvalid, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_gnt, dm_rvalid, dm_err;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int tests_run = 0;
  int failures  = 0;
  int cyc = 0;
  int rv_count = 0;
  int last_gnt_cyc, last_if_gnt_cyc, last_rv_cyc, last_dm_rv_cyc, ack_cyc;
  int rv_base, rv_before;
  int req_cnt = 0;
  int ack_delay = 0;
  logic mem_en = 1'b1;
  logic stray_ack = 1'b0;
  logic        exp_we;
  logic [3:0]  exp_be;
  logic [31:0] exp_addr, exp_wdata;
  logic [4:0]  log_bits;
  exp_t        sb[$];
  logic        gnt_log[$];
  logic [31:0] mem [logic [31:0]];

  mem_port_arbiter #(
    .DATA_WIDTH     (32),
    .MAX_DM_STREAK  (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .i_clk       (clk),
    .i_reset_n   (i_reset_n),
    .i_if_req    (if_req),
    .i_if_addr   (if_addr),
    .o_if_gnt    (if_gnt),
    .o_if_rvalid (if_rvalid),
    .o_if_rdata  (if_rdata),
    .o_if_err    (if_err),
    .i_dm_req    (dm_req),
    .i_dm_we     (dm_we),
    .i_dm_be     (dm_be),
    .i_dm_addr   (dm_addr),
    .i_dm_wdata  (dm_wdata),
    .o_dm_gnt    (dm_gnt),
    .o_dm_rvalid (dm_rvalid),
    .o_dm_rdata  (dm_rdata),
    .o_dm_err    (dm_err),
    .o_mem_req   (mem_req),
    .o_mem_we    (mem_we),
    .o_mem_be    (mem_be),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .i_mem_ack   (mem_ack),
    .i_mem_rdata (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return ~a;
  endfunction

  task automatic at_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rv(input int target);
    logic seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      at_neg();
      seen = (rv_count >= target);
    end
    chk("wait_rvalid", seen, 1);
  endtask

  task automatic wait_gnt(input logic want_dm, input int budget);
    logic seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      at_neg();
      seen = want_dm ? dm_gnt : if_gnt;
    end
    chk("wait_gnt", seen, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {if_gnt, if_rvalid, if_err, dm_gnt, dm_rvalid, dm_err, mem_req, mem_we, mem_be}, 0);
    chk({tag, "_data"}, {if_rdata, dm_rdata}, 0);
    chk({tag, "_mem"}, {mem_addr, mem_wdata}, 0);
  endtask

  // Memory responder: acks after ack_delay extra request cycles; stray_ack injects a bare ack.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      logic [31:0] v;
      at_pos();
      req_cnt   = mem_req ? req_cnt + 1 : 0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      if (stray_ack) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
      end else if (mem_en && mem_req && req_cnt == ack_delay + 1) begin
        mem_ack = 1'b1;
        if (mem_we) begin
          mem_rdata = 32'hBAD0_BAD0;
          v = mem_val(mem_addr);
          for (int b = 0; b < 4; b++) if (mem_be[b]) v[8*b +: 8] = mem_wdata[8*b +: 8];
          mem[mem_addr] = v;
        end else begin
          mem_rdata = mem_val(mem_addr);
        end
      end
    end
  end

  // Monitor: pushes expectations on grants, checks held request fields and completions.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (i_reset_n) begin
      chk("gnt_exclusive", if_gnt & dm_gnt, 0);
      if (if_gnt) begin
        sb.push_back('{1'b0, mem_en ? mem_val(if_addr) : 32'h0, !mem_en});
        {exp_we, exp_be, exp_addr, exp_wdata} = {1'b0, 4'hF, if_addr, 32'h0};
        gnt_log.push_back(1'b0);
        last_gnt_cyc    = cyc;
        last_if_gnt_cyc = cyc;
      end
      if (dm_gnt) begin
        sb.push_back('{1'b1, (mem_en && !dm_we) ? mem_val(dm_addr) : 32'h0, !mem_en});
        {exp_we, exp_be, exp_addr, exp_wdata} = {dm_we, dm_be, dm_addr, dm_wdata};
        gnt_log.push_back(1'b1);
        last_gnt_cyc = cyc;
      end
      if (mem_req) begin
        chk("mem_ctl_stable", {mem_we, mem_be}, {exp_we, exp_be});
        chk("mem_data_stable", {mem_addr, mem_wdata}, {exp_addr, exp_wdata});
      end
      if (mem_ack && mem_req) ack_cyc = cyc;
      if (if_rvalid || dm_rvalid) begin
        chk("rvalid_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("rvalid_who", {dm_rvalid, if_rvalid}, e.is_dm ? 2'b10 : 2'b01);
          chk("rvalid_rdata", dm_rvalid ? dm_rdata : if_rdata, e.rdata);
          chk("rvalid_err", dm_rvalid ? dm_err : if_err, e.err);
          if (!e.err) chk("ack_to_rvalid", cyc - ack_cyc, 1);
        end
        rv_count++;
        last_rv_cyc = cyc;
        if (dm_rvalid) last_dm_rv_cyc = cyc;
      end
    end
  end

  initial begin
    i_reset_n = 1'b1;
    if_req = 0; if_addr = '0;
    dm_req = 0; dm_we = 0; dm_be = '0; dm_addr = '0; dm_wdata = '0;
    #2 i_reset_n = 1'b0;
    at_neg();
    at_neg();
    chk_all_zero("reset_outputs");
    at_pos();
    i_reset_n = 1'b1;

    // IF-only read, ack in the third request cycle
    mem[32'h10] = 32'h0000_0093;
    ack_delay = 2;
    at_pos();
    if_req = 1; if_addr = 32'h10;
    at_neg();
    chk("t1_if_gnt", {if_gnt, dm_gnt}, 2'b10);
    at_pos();
    if_req = 0; if_addr = '0;
    rv_base = rv_count;
    wait_rv(rv_base + 1);
    chk("t1_gnt_to_rvalid", last_rv_cyc - last_gnt_cyc, 4);
    at_neg();
    at_neg();
    chk("t1_rdata_hold", if_rdata, 32'h93);
    chk("t1_err_low", if_err, 0);

    // Simultaneous IF and DM: DM first, IF right after DM's RESP
    mem[32'h100] = 32'h1234_5678;
    ack_delay = 0;
    at_pos();
    if_req = 1; if_addr = 32'h20;
    dm_req = 1; dm_we = 0; dm_be = 4'hF; dm_addr = 32'h100;
    at_neg();
    chk("t2_dm_first", {if_gnt, dm_gnt}, 2'b01);
    rv_base = rv_count;
    at_pos();
    dm_req = 0;
    wait_gnt(1'b0, 20);
    chk("t2_if_after_resp", last_if_gnt_cyc - last_dm_rv_cyc, 1);
    at_pos();
    if_req = 0;
    wait_rv(rv_base + 2);

    // Anti-starvation: DM held with IF pending
    ack_delay = 1;
    gnt_log.delete();
    rv_base = rv_count;
    at_pos();
    if_req = 1; if_addr = 32'h40;
    dm_req = 1; dm_we = 0; dm_addr = 32'h104;
    wait_gnt(1'b0, 100);
    at_pos();
    if_req = 0; dm_req = 0;
    wait_rv(rv_base + 5);
    chk("t3_grant_count", gnt_log.size(), 5);
    log_bits = '0;
    for (int i = 0; i < gnt_log.size() && i < 5; i++) log_bits[4-i] = gnt_log[i];
    chk("t3_grant_order", log_bits, 5'b11110);
    rv_base = rv_count;
    at_pos();
    if_req = 1; dm_req = 1;
    at_neg();
    chk("t3_streak_cleared", {if_gnt, dm_gnt}, 2'b01);
    at_pos();
    dm_req = 0;
    wait_gnt(1'b0, 20);
    at_pos();
    if_req = 0;
    wait_rv(rv_base + 2);

    // DM partial store; inputs scrambled after grant
    ack_delay = 3;
    rv_base = rv_count;
    at_pos();
    dm_req = 1; dm_we = 1; dm_be = 4'b0011; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF;
    at_neg();
    chk("t4_dm_gnt", {if_gnt, dm_gnt}, 2'b01);
    at_pos();
    dm_req = 0; dm_we = 0; dm_be = 4'hF; dm_addr = 32'hFFFF_FFFC; dm_wdata = '0;
    at_neg();
    chk("t4_mem_ctl", {mem_req, mem_we, mem_be}, {1'b1, 1'b1, 4'b0011});
    chk("t4_mem_addr", mem_addr, 32'h200);
    chk("t4_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    wait_rv(rv_base + 1);
    chk("t4_store_rdata", dm_rdata, 0);

    // Timeout: no ack, stray acks in RESP and IDLE
    mem_en = 1'b0;
    rv_base = rv_count;
    at_pos();
    if_req = 1; if_addr = 32'h300;
    wait_gnt(1'b0, 5);
    at_pos();
    if_req = 0;
    for (int i = 1; i <= 8; i++) begin
      at_neg();
      chk("t5_req_held", mem_req, 1);
      if (i == 8) stray_ack = 1'b1;
    end
    at_neg();
    chk("t5_req_dropped", mem_req, 0);
    chk("t5_timeout_resp", {if_rvalid, if_err, if_rdata}, {1'b1, 1'b1, 32'h0});
    at_neg();
    stray_ack = 1'b0;
    rv_before = rv_count;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("t5_stray_ignored", {if_rvalid, dm_rvalid, mem_req, if_err}, 0);
    end
    chk("t5_no_extra_rvalid", rv_count - rv_before, 0);
    chk("t5_rvalid_count", rv_count - rv_base, 1);

    // Ack on the last busy cycle beats the timeout
    at_pos();
    mem_en = 1'b1;
    ack_delay = 7;
    mem[32'h14] = 32'h0000_0013;
    rv_base = rv_count;
    at_pos();
    if_req = 1; if_addr = 32'h14;
    at_neg();
    chk("t5b_if_gnt", {if_gnt, dm_gnt}, 2'b10);
    at_pos();
    if_req = 0;
    wait_rv(rv_base + 1);
    chk("t5b_ack_wins_latency", last_rv_cyc - last_gnt_cyc, 9);

    // Reset while BUSY_DM
    mem_en = 1'b0;
    at_pos();
    dm_req = 1; dm_we = 0; dm_be = 4'hF; dm_addr = 32'h104;
    at_neg();
    chk("t6_dm_gnt", {if_gnt, dm_gnt}, 2'b01);
    at_pos();
    dm_req = 0;
    at_neg();
    at_neg();
    chk("t6_in_flight", mem_req, 1);
    rv_before = rv_count;
    #1 i_reset_n = 1'b0;
    #1 chk_all_zero("t6_async_reset");
    sb.delete();
    at_pos();
    at_pos();
    i_reset_n = 1'b1;
    mem_en = 1'b1;
    ack_delay = 0;
    chk("t6_no_rvalid", rv_count - rv_before, 0);
    rv_base = rv_count;
    if_req = 1; if_addr = 32'h10;
    at_neg();
    chk("t6_if_gnt_after_reset", {if_gnt, dm_gnt}, 2'b10);
    at_pos();
    if_req = 0;
    wait_rv(rv_base + 1);
    at_neg();
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
